// File: rtl/serial_negator_if.sv
//------------------------------------------------------------------------------
// serial_negator_if
// Operand/result handshake bundle for the serial negation engine.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_negator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    // Producer/consumer side: offers operands and accepts results
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    // Engine side
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_negator.sv
//------------------------------------------------------------------------------
// serial_negator
// Digit-serial two's complement pass / negate / absolute-value engine.
// One DIGIT-bit adder slice with a registered carry, LSB first.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_negator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_negator_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_negator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] result_q;
    logic             inv_q;
    logic             carry_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic                   accept;
    logic                   inv_in;
    logic [DIGIT:0]         sum;
    logic [WIDTH+DIGIT-1:0] result_cat;

    // inv selects ones' complement plus carry-in 1, i.e. negation
    assign inv_in = (bus.in_mode == 2'b01) ||
                    ((bus.in_mode == 2'b10) && bus.in_data[WIDTH-1]);
    assign accept = bus.in_valid && (state == IDLE);

    // Single digit slice: conditionally inverted digit plus running carry
    assign sum = {1'b0, shift_q[DIGIT-1:0] ^ {DIGIT{inv_q}}} +
                 {{DIGIT{1'b0}}, carry_q};

    // New digit enters the result from the top; concatenation avoids an
    // empty slice when WIDTH == DIGIT
    assign result_cat = {sum[DIGIT-1:0], result_q};

    // Control FSM and serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            result_q <= '0;
            inv_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_q <= bus.in_data;
                        inv_q   <= inv_in;
                        carry_q <= inv_in;
                        ovf_q   <= inv_in && (bus.in_data == MOST_NEG);
                        cnt_q   <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    shift_q  <= shift_q >> DIGIT;
                    result_q <= result_cat[WIDTH+DIGIT-1:DIGIT];
                    carry_q  <= sum[DIGIT];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and result outputs decoded from registered state only
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = result_q;
    assign bus.out_ovf   = (state == DONE) && ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_negator.sv
//------------------------------------------------------------------------------
// tb_serial_negator
// Directed bench for serial_negator at 8/1 and 16/4 configurations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_negator;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    serial_negator_if #(.WIDTH(8))  bus8 ();
    serial_negator_if #(.WIDTH(16)) bus16 ();

    serial_negator #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_negator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand to the 8-bit engine and wait for its result
    task automatic run8(input logic [7:0] d, input logic [1:0] m,
                        input logic [7:0] exp_d, input logic exp_o,
                        input string tag, input bit release_out);
        int  cyc;
        bit  ready_seen;
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        bus8.in_mode  = m;
        tick();
        bus8.in_valid = 1'b0;
        bus8.in_data  = 8'h00;
        cyc = 0;
        ready_seen = 1'b0;
        while (!bus8.out_valid && cyc < 100) begin
            if (bus8.in_ready) ready_seen = 1'b1;
            tick();
            cyc++;
        end
        if (bus8.in_ready) ready_seen = 1'b1;
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_ready_low"}, {31'd0, ready_seen}, 0);
        chk({tag, "_data"}, {24'd0, bus8.out_data}, {24'd0, exp_d});
        chk({tag, "_ovf"}, {31'd0, bus8.out_ovf}, {31'd0, exp_o});
        if (release_out) begin
            bus8.out_ready = 1'b1;
            tick();
            bus8.out_ready = 1'b0;
            chk({tag, "_idle"}, {30'd0, bus8.out_valid, bus8.in_ready}, 32'd1);
        end
    endtask

    task automatic run16(input logic [15:0] d, input logic [1:0] m,
                         input logic [15:0] exp_d, input logic exp_o, input string tag);
        int cyc;
        bus16.in_valid = 1'b1;
        bus16.in_data  = d;
        bus16.in_mode  = m;
        tick();
        bus16.in_valid = 1'b0;
        cyc = 0;
        while (!bus16.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 4);
        chk({tag, "_data"}, {16'd0, bus16.out_data}, {16'd0, exp_d});
        chk({tag, "_ovf"}, {31'd0, bus16.out_ovf}, {31'd0, exp_o});
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, bus16.out_valid, bus16.in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] held_d;
        logic       held_o;
        int         cyc;
        bit         seen;
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        bus8.in_valid  = 1'b0; bus8.in_data  = '0; bus8.in_mode  = 2'b00; bus8.out_ready  = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_mode = 2'b00; bus16.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus8.in_ready}, 0);
        chk("rst_outs", {21'd0, bus8.out_valid, bus8.out_ovf, bus8.busy, bus8.out_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {31'd0, bus8.in_ready}, 1);

        // Functional vectors, 8-bit digit-serial
        run8(8'h05, 2'b01, 8'hFB, 1'b0, "neg05", 1'b1);
        run8(8'hF0, 2'b10, 8'h10, 1'b0, "absF0", 1'b1);
        run8(8'h80, 2'b10, 8'h80, 1'b1, "abs80", 1'b1);
        run8(8'h7F, 2'b10, 8'h7F, 1'b0, "abs7F", 1'b1);
        run8(8'h3C, 2'b00, 8'h3C, 1'b0, "pass3C", 1'b1);
        run8(8'hA5, 2'b11, 8'hA5, 1'b0, "resA5", 1'b1);
        run8(8'h00, 2'b01, 8'h00, 1'b0, "neg00", 1'b1);
        run8(8'h80, 2'b01, 8'h80, 1'b1, "neg80", 1'b1);

        // 16-bit, 4 bits per cycle
        run16(16'h0001, 2'b01, 16'hFFFF, 1'b0, "w16_neg0001");
        run16(16'h1234, 2'b01, 16'hEDCC, 1'b0, "w16_neg1234");

        // Backpressure: result must stay put and new operands be ignored
        run8(8'h80, 2'b01, 8'h80, 1'b1, "bp", 1'b0);
        held_d = bus8.out_data;
        held_o = bus8.out_ovf;
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h11;
        bus8.in_mode  = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus8.out_data !== held_d || bus8.out_ovf !== held_o ||
                bus8.in_ready !== 1'b0 || bus8.out_valid !== 1'b1) seen = 1'b1;
        end
        chk("bp_stable", {31'd0, seen}, 0);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        chk("bp_handshake", {29'd0, bus8.out_valid, bus8.in_ready, bus8.busy}, 32'd2);
        tick();
        chk("bp_no_accept", {30'd0, bus8.busy, bus8.in_ready}, 32'd1);

        // Reset in the middle of BUSY discards the operation
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h05;
        bus8.in_mode  = 2'b01;
        tick();
        bus8.in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_busy", {31'd0, bus8.busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {20'd0, bus8.in_ready, bus8.out_valid, bus8.out_ovf, bus8.busy, bus8.out_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_ready", {31'd0, bus8.in_ready}, 1);
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 12) begin
            if (bus8.out_valid || bus8.busy) seen = 1'b1;
            tick();
            cyc++;
        end
        chk("mid_rst_no_out", {31'd0, seen}, 0);
        run8(8'h01, 2'b01, 8'hFF, 1'b0, "post_rst", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
